four_bit_div_controller: RTL and testbench
==========================================

FOUR_BIT_DIV_CONTROLLER -- requirements
Module: four_bit_div_controller

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, operand/result bit width.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 SHALL have port: clock  input  1  rising-edge clock for all state.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: init  input  1  start request; sampled only in IDLE.
REQ-006 SHALL have port: dividend  input  WIDTH  unsigned dividend; captured when init is accepted.
REQ-007 SHALL have port: divisor  input  WIDTH  unsigned divisor; captured when init is accepted.
REQ-008 SHALL have port: busy  output  1  high while a division is in progress.
REQ-009 SHALL have port: done  output  1  single-cycle pulse when results are valid.
REQ-010 SHALL have port: quotient  output  WIDTH  quotient register.
REQ-011 SHALL have port: remainder  output  WIDTH  remainder register.
REQ-012 SHALL have port: div_zero  output  1  divide-by-zero flag, valid with done.

Function
REQ-013 SHALL implement an unsigned restoring shift-subtract divider, the inverse of the shift-add multiplier controller.
REQ-014 SHALL have states IDLE, RUN, DONE; 2-bit encoding.
REQ-015 SHALL, in IDLE with init=1, load remainder=0, quotient=dividend and divisor_ff=divisor, set count=WIDTH and go to RUN.
REQ-016 SHALL, each RUN cycle, form {remainder,quotient}<<1 and trial=shifted remainder minus divisor_ff at WIDTH+1 bits.
REQ-017 SHALL, when trial is non-negative (MSB 0), set remainder=trial[WIDTH-1:0] and quotient[0]=1; otherwise keep the shifted remainder and set quotient[0]=0.
REQ-018 SHALL decrement count each RUN cycle and go RUN->DONE when count reaches 1 in that cycle, giving exactly WIDTH RUN cycles.
REQ-019 SHALL assert done for exactly the one DONE cycle, then go DONE->IDLE unconditionally.
REQ-020 SHALL give latency from init-accept edge to done-high of WIDTH+1 cycles (5 at WIDTH=4).
REQ-021 SHALL drive busy=1 in RUN and DONE, and 0 in IDLE.
REQ-022 SHALL ignore init when not in IDLE, with no effect on captured operands or progress.
REQ-023 SHALL hold quotient and remainder stable after DONE until the next accepted init.
REQ-024 SHALL, when init is held high continuously, start a new operation in the first IDLE cycle after DONE.
REQ-025 SHALL keep operand inputs don't-care except on the accept cycle.

Reset
REQ-026 SHALL, on reset at a clock edge, force state=IDLE, count=0, quotient=0, remainder=0, divisor_ff=0, busy=0, done=0, div_zero=0.
REQ-027 SHALL let reset take priority over init and abort an in-progress division without asserting done.

Configuration
REQ-028 SHALL use macro DIV_ZERO_CHECK_EN.
REQ-029 SHALL, when DIV_ZERO_CHECK_EN is defined and init is accepted with divisor=0, go directly IDLE->DONE, load quotient=all-ones and remainder=dividend, and assert div_zero=1 with done (latency 1).
REQ-030 SHALL, when DIV_ZERO_CHECK_EN is defined, clear div_zero on the next accepted init.
REQ-031 SHALL, when DIV_ZERO_CHECK_EN is undefined, tie div_zero to 0 and run a zero divisor through the normal WIDTH-cycle algorithm (naturally yielding quotient=all-ones, remainder=dividend).

Structure
REQ-032 SHALL place in shared package div_pkg: the state typedef (IDLE/RUN/DONE) and the default-width constant DIV_WIDTH=4.
REQ-033 SHALL implement the trial-subtract/restore step (inputs shifted remainder and divisor; outputs next remainder and quotient bit) as sub-module div_step; the FSM, counter and registers stay in the top.

Verification
REQ-034 SHALL verify: dividend=13, divisor=3, init one cycle -> done 5 cycles later, quotient=4, remainder=1, div_zero=0.
REQ-035 SHALL verify: 15/1 -> quotient=15, remainder=0; 3/7 -> quotient=0, remainder=3; 15/15 -> quotient=1, remainder=0.
REQ-036 SHALL verify: 9/0 with DIV_ZERO_CHECK_EN -> done 1 cycle later, quotient=15, remainder=9, div_zero=1; without the macro -> done after 5 cycles, same values, div_zero=0.
REQ-037 SHALL verify: start 13/3, pulse init with 8/2 during RUN -> result still 4 rem 1; busy high for 5 cycles.
REQ-038 SHALL verify: start 13/3, assert reset in the 3rd RUN cycle -> next cycle IDLE, all outputs 0, no done pulse; a following 8/2 gives 4 rem 0.
REQ-039 SHALL verify: init held high across back-to-back 14/4 operations -> done pulses 6 cycles apart, each giving quotient=3, remainder=2.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: the controller state type and the default operand width.
package div_pkg;

    localparam int DIV_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted partial remainder and
// keep either the difference or the original value, producing one quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   shifted_rem,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0] trial;

    // The extra top bit acts as the sign of the trial difference; when negative the restore
    // value always fits in WIDTH bits because the shifted remainder is then below the divisor.
    always_comb begin
        trial    = shifted_rem - {1'b0, divisor};
        q_bit    = ~trial[WIDTH];
        next_rem = q_bit ? trial[WIDTH-1:0] : shifted_rem[WIDTH-1:0];
    end

endmodule

// File: rtl/four_bit_div_controller.sv
// Unsigned restoring shift-subtract divider: IDLE -> RUN (WIDTH steps) -> DONE.
// Optional macro DIV_ZERO_CHECK_EN short-circuits a zero divisor straight to DONE and flags div_zero.
module four_bit_div_controller
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             init,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t     state;
    div_state_t     next_state;
    logic [CW-1:0]  count;
    logic [WIDTH-1:0] divisor_ff;
    logic [WIDTH-1:0] step_rem;
    logic           step_q;
    logic           accept;
`ifdef DIV_ZERO_CHECK_EN
    logic           zero_fast;
`endif

    // The partial remainder gains the quotient MSB as it shifts in, so it is WIDTH+1 bits wide.
    div_step #(.WIDTH(WIDTH)) u_step (
        .shifted_rem ({remainder, quotient[WIDTH-1]}),
        .divisor     (divisor_ff),
        .next_rem    (step_rem),
        .q_bit       (step_q)
    );

    always_comb begin
        next_state = state;
        accept     = 1'b0;
`ifdef DIV_ZERO_CHECK_EN
        zero_fast  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (init) begin
                    accept     = 1'b1;
`ifdef DIV_ZERO_CHECK_EN
                    zero_fast  = (divisor == '0);
                    next_state = zero_fast ? DONE : RUN;
`else
                    next_state = RUN;
`endif
                end
            end
            RUN: begin
                if (count == CW'(1)) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            quotient   <= '0;
            remainder  <= '0;
            divisor_ff <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                divisor_ff <= divisor;
                count      <= CW'(WIDTH);
`ifdef DIV_ZERO_CHECK_EN
                if (zero_fast) begin
                    quotient  <= '1;
                    remainder <= dividend;
                end else begin
                    quotient  <= dividend;
                    remainder <= '0;
                end
`else
                quotient  <= dividend;
                remainder <= '0;
`endif
            end else if (state == RUN) begin
                remainder <= step_rem;
                quotient  <= {quotient[WIDTH-2:0], step_q};
                count     <= count - CW'(1);
            end
        end
    end

`ifdef DIV_ZERO_CHECK_EN
    // Flag follows each accepted operation, so a normal divide clears a stale zero flag.
    always_ff @(posedge clock) begin
        if (reset)       div_zero <= 1'b0;
        else if (accept) div_zero <= zero_fast;
    end
`else
    assign div_zero = 1'b0;
`endif

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_four_bit_div_controller.sv
// Self-checking bench for four_bit_div_controller: arithmetic reference model plus directed vectors.
// Expectations for the zero-divisor case follow whether DIV_ZERO_CHECK_EN is defined.
module tb_four_bit_div_controller;
    import div_pkg::*;

    localparam int WIDTH = DIV_WIDTH;
    localparam int ALL_ONES = (1 << WIDTH) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             init;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    int checks = 0;
    int passed = 0;

    // Reference model state: cycles left busy (DONE is the last), pending and visible results.
    int m_left = 0;
    int m_q = 0, m_r = 0, m_pq = 0, m_pr = 0, m_dz = 0;
    bit m_known = 1'b0;
    bit model_ready = 1'b0;

    four_bit_div_controller #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .init      (init),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Model works from plain division: results appear WIDTH+1 cycles after acceptance.
    always @(posedge clock) begin
        if (reset) begin
            m_left = 0; m_q = 0; m_r = 0; m_dz = 0; m_known = 1'b1; model_ready = 1'b1;
        end else if (m_left == 0) begin
            if (init) begin
                m_pq = (divisor == 0) ? ALL_ONES : int'(dividend) / int'(divisor);
                m_pr = (divisor == 0) ? int'(dividend) : int'(dividend) % int'(divisor);
                m_known = 1'b0;
                m_dz = 0;
                m_left = WIDTH + 1;
`ifdef DIV_ZERO_CHECK_EN
                if (divisor == 0) begin
                    m_left = 1;
                    m_dz = 1;
                end
`endif
                if (m_left == 1) begin m_q = m_pq; m_r = m_pr; m_known = 1'b1; end
            end
        end else begin
            m_left--;
            if (m_left == 1) begin m_q = m_pq; m_r = m_pr; m_known = 1'b1; end
        end
    end

    always @(negedge clock) begin
        if (model_ready) begin
            checkOutput("model busy", busy, int'(m_left > 0));
            checkOutput("model done", done, int'(m_left == 1));
            checkOutput("model div_zero", div_zero, m_dz);
            if (m_known) begin
                checkOutput("model quotient", quotient, m_q);
                checkOutput("model remainder", remainder, m_r);
            end
        end
    end

    task automatic applyStimulus(input int a, input int b);
        @(negedge clock);
        init = 1'b1;
        dividend = WIDTH'(a);
        divisor = WIDTH'(b);
    endtask

    // mode 1 pulses a competing 8/2 request while the first division is running.
    task automatic runOp(input string name, input int a, input int b, input int exp_q,
                         input int exp_r, input int exp_dz, input int exp_lat, input int mode);
        int lat = 0;
        int busy_cycles = 0;
        applyStimulus(a, b);
        do begin
            @(negedge clock);
            lat++;
            if (busy) busy_cycles++;
            if (lat == 1) begin
                init = 1'b0;
                dividend = WIDTH'($urandom);
                divisor = WIDTH'($urandom);
            end
            if (mode == 1 && lat == 2) begin init = 1'b1; dividend = 8; divisor = 2; end
            if (mode == 1 && lat == 3) init = 1'b0;
        end while (!done && lat < 20);
        checkOutput({name, " latency"}, lat, exp_lat);
        checkOutput({name, " quotient"}, quotient, exp_q);
        checkOutput({name, " remainder"}, remainder, exp_r);
        checkOutput({name, " div_zero"}, div_zero, exp_dz);
        if (mode == 1) checkOutput({name, " busy cycles"}, busy_cycles, 5);
    endtask

    initial begin
        int t;
        int first_done;
        int second_done;
        bit saw_done;

        reset = 1'b1; init = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset quotient", quotient, 0);
        checkOutput("reset remainder", remainder, 0);
        checkOutput("reset div_zero", div_zero, 0);

        runOp("13/3", 13, 3, 4, 1, 0, 5, 0);
        runOp("15/1", 15, 1, 15, 0, 0, 5, 0);
        runOp("3/7", 3, 7, 0, 3, 0, 5, 0);
        runOp("15/15", 15, 15, 1, 0, 0, 5, 0);
`ifdef DIV_ZERO_CHECK_EN
        runOp("9/0", 9, 0, 15, 9, 1, 1, 0);
`else
        runOp("9/0", 9, 0, 15, 9, 0, 5, 0);
`endif
        runOp("13/3 init in run", 13, 3, 4, 1, 0, 5, 1);

        // Abort in the third RUN cycle.
        applyStimulus(13, 3);
        @(negedge clock); init = 1'b0;
        @(negedge clock);
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        checkOutput("abort busy", busy, 0);
        checkOutput("abort done", done, 0);
        checkOutput("abort quotient", quotient, 0);
        checkOutput("abort remainder", remainder, 0);
        checkOutput("abort div_zero", div_zero, 0);
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (done) saw_done = 1'b1;
        end
        checkOutput("abort no done", saw_done, 0);
        runOp("8/2 after reset", 8, 2, 4, 0, 0, 5, 0);

        // init held high across two back-to-back 14/4 operations.
        applyStimulus(14, 4);
        t = 0; first_done = -1; second_done = -1;
        while (second_done < 0 && t < 30) begin
            @(negedge clock);
            t++;
            if (done) begin
                checkOutput("b2b quotient", quotient, 3);
                checkOutput("b2b remainder", remainder, 2);
                if (first_done < 0) first_done = t;
                else second_done = t;
            end
        end
        init = 1'b0;
        checkOutput("b2b first done", first_done, 5);
        checkOutput("b2b spacing", second_done - first_done, 6);

        repeat (4) @(negedge clock);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
